// File: rtl/vdc_block_engine_if.sv
// Bundle of command, status and RAM-bus signals for the VDC block engine.
// The master modport is the engine itself (it masters the RAM bus); the
// slave modport is the surrounding controller/RAM side.
interface vdc_block_engine_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
);
    logic                     start;
    logic                     copy;
    logic [7:0]               count;
    logic [ADDRESS_WIDTH-1:0] src_addr;
    logic [ADDRESS_WIDTH-1:0] dst_addr;
    logic [DATA_WIDTH-1:0]    fill_data;
    logic                     slot;
    logic [DATA_WIDTH-1:0]    ram_din;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic                     ram_we;
    logic [DATA_WIDTH-1:0]    ram_dout;
    logic                     busy;
    logic                     done;
    logic [ADDRESS_WIDTH-1:0] src_next;
    logic [ADDRESS_WIDTH-1:0] dst_next;

    modport master (
        input  start, copy, count, src_addr, dst_addr, fill_data, slot, ram_din,
        output ram_addr, ram_we, ram_dout, busy, done, src_next, dst_next
    );

    modport slave (
        output start, copy, count, src_addr, dst_addr, fill_data, slot, ram_din,
        input  ram_addr, ram_we, ram_dout, busy, done, src_next, dst_next
    );
endinterface

// File: rtl/vdc_block_engine.sv
// VDC block engine: block copy (read, capture, write per byte) and block
// fill (one write per byte) over a slot-arbitrated single-port VDC RAM.
// Addresses walk upward and wrap at the top of the address space.
module vdc_block_engine #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    vdc_block_engine_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        FILL
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] src_ptr;
    logic [ADDRESS_WIDTH-1:0] dst_ptr;
    logic [8:0]               remaining;
    logic [DATA_WIDTH-1:0]    data_reg;
    logic [DATA_WIDTH-1:0]    fill_reg;
    logic                     done_reg;
    logic                     last_byte;

    assign last_byte = (remaining <= 9'd1);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; RAM-touching states only move on when slot is granted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = bus.copy ? RD : FILL;
                end
            end
            RD: begin
                if (bus.slot) begin
                    state_next = CAP;
                end
            end
            CAP: begin
                state_next = WR;
            end
            WR: begin
                if (bus.slot) begin
                    state_next = last_byte ? IDLE : RD;
                end
            end
            FILL: begin
                if (bus.slot && last_byte) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch the command, step pointers/count per granted access, flag done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_reg  <= '0;
            fill_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_ptr   <= bus.src_addr;
                        dst_ptr   <= bus.dst_addr;
                        remaining <= (bus.count == 8'd0) ? 9'd256 : {1'b0, bus.count};
                        fill_reg  <= bus.fill_data;
                    end
                end
                RD: begin
                    if (bus.slot) begin
                        src_ptr <= src_ptr + ADDR_ONE;
                    end
                end
                CAP: begin
                    data_reg <= bus.ram_din;
                end
                WR, FILL: begin
                    if (bus.slot) begin
                        dst_ptr   <= dst_ptr + ADDR_ONE;
                        remaining <= remaining - 9'd1;
                        done_reg  <= last_byte;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM bus drive; write enable is raised for the whole write state and the arbiter gates it with slot.
    always_comb begin
        bus.ram_addr = dst_ptr;
        bus.ram_we   = 1'b0;
        bus.ram_dout = '0;
        case (state)
            RD: begin
                bus.ram_addr = src_ptr;
            end
            CAP: begin
                bus.ram_addr = src_ptr - ADDR_ONE;
            end
            WR: begin
                bus.ram_we   = 1'b1;
                bus.ram_dout = data_reg;
            end
            FILL: begin
                bus.ram_we   = 1'b1;
                bus.ram_dout = fill_reg;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_reg;
    assign bus.src_next = src_ptr;
    assign bus.dst_next = dst_ptr;

endmodule

// File: doc/vdc_block_engine.md
VDC_BLOCK_ENGINE -- requirements
Module: vdc_block_engine

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, the VDC RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the VDC RAM data width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, sole clock, rising edge.
REQ-005 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port start: input, 1 bit, one-cycle request to begin an operation; sampled only in IDLE.
REQ-007 Port copy: input, 1 bit, sampled with start; 1 = block copy, 0 = block fill.
REQ-008 Port count: input, 8 bits, sampled with start; byte count, where 0 means 256.
REQ-009 Port src_addr: input, ADDRESS_WIDTH bits, sampled with start; copy source start address.
REQ-010 Port dst_addr: input, ADDRESS_WIDTH bits, sampled with start; destination start address.
REQ-011 Port fill_data: input, DATA_WIDTH bits, sampled with start; fill byte.
REQ-012 Port slot: input, 1 bit, RAM access grant; RAM-touching states advance only when slot=1.
REQ-013 Port ram_din: input, DATA_WIDTH bits, RAM read data, valid the cycle after the address is clocked in.
REQ-014 Port ram_addr: output, ADDRESS_WIDTH bits, RAM address.
REQ-015 Port ram_we: output, 1 bit, RAM write enable.
REQ-016 Port ram_dout: output, DATA_WIDTH bits, RAM write data.
REQ-017 Port busy: output, 1 bit, high in any state other than IDLE.
REQ-018 Port done: output, 1 bit, one-cycle pulse after the last byte is written.
REQ-019 Port src_next: output, ADDRESS_WIDTH bits, running source pointer.
REQ-020 Port dst_next: output, ADDRESS_WIDTH bits, running destination pointer.

Function
REQ-021 States SHALL be IDLE, RD, CAP, WR and FILL.
REQ-022 IDLE + start: latch inputs, load remaining count (0 loads 256, 9-bit counter), and go to RD if copy=1, else FILL.
REQ-023 start while busy SHALL be ignored; no restart, no latch update.
REQ-024 RD: ram_addr=src pointer, ram_we=0; on slot=1 go to CAP and increment src pointer; on slot=0 hold state.
REQ-025 CAP: ram_addr holds the previous src address, ram_we=0; capture ram_din into the data register; go to WR unconditionally after 1 cycle.
REQ-026 WR: ram_addr=dst pointer, ram_we=1, ram_dout=data register; on slot=1, increment dst pointer, decrement count, then go to RD if count>1, else IDLE with done.
REQ-027 FILL: ram_addr=dst pointer, ram_we=1, ram_dout=fill byte; on slot=1, increment dst, decrement count; on the last byte go to IDLE with done.
REQ-028 ram_we SHALL be 1 only in WR or FILL, including cycles with slot=0; the external arbiter gates we by slot.
REQ-029 Pointer arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH (0xFFFF+1 = 0x0000).
REQ-030 src_next and dst_next SHALL reflect the pointers after each completed access and SHALL hold their final values in IDLE.
REQ-031 In IDLE: ram_we=0, ram_addr=dst_next, ram_dout=0.
REQ-032 done SHALL assert for exactly the cycle after the final write edge, coincident with busy=0.
REQ-033 Copy throughput SHALL be 3 cycles per byte with slot held at 1; fill throughput SHALL be 1 cycle per byte.
REQ-034 Overlapping source and destination ranges SHALL be processed strictly in ascending address order, with no hazard handling.

Reset
REQ-035 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, ram_we=0, pointers=0, count=0, data register=0, ram_addr=0, ram_dout=0.
REQ-036 Reset mid-operation SHALL abandon the operation with no further writes; the first start after reset behaves as a fresh operation.

Verification
REQ-037 Fill test: slot=1, fill dst=0x1000, count=4, fill_data=0xA5. Required: 0x1000-0x1003=0xA5, 0x1004 unchanged, done at cycle 5 after start, dst_next=0x1004.
REQ-038 Copy test: source bytes 0x2000-0x2002 = 11,22,33; copy to 0x3000 with count=3. Required: 0x3000-0x3002 = 11,22,33, 9 busy cycles, src_next=0x2003, dst_next=0x3003.
REQ-039 Count=0 fill at 0xFFF0. Required: 256 bytes written, wrapping to 0x00EF; dst_next=0x00F0.
REQ-040 slot toggling 1,0,1,0 during a copy of count=2. Required: the engine stalls in RD/WR while slot=0, data is correct, and no extra increments occur.
REQ-041 reset_n pulsed low after 2 bytes of a count=8 fill. Required: busy=0 immediately, no further writes, pointers=0.
REQ-042 start pulsed while busy. Required: it is ignored and the original operation completes unchanged.
